// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : imm_decode_stage
// Purpose  : RISC-V immediate/format decoder with pc-relative target, held in a
//            single registered valid/ready pipeline slot.
// Revision : 1.0 - initial release
// ============================================================================
module imm_decode_stage #(
  parameter int XLEN = 32  // 32 or 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] immediate_out,
  output logic [2:0]      fmt_out,
  output logic [XLEN-1:0] target_out,
  output logic            illegal_out
);

  localparam logic [2:0] c_fmt_r     = 3'd0;
  localparam logic [2:0] c_fmt_i     = 3'd1;
  localparam logic [2:0] c_fmt_s     = 3'd2;
  localparam logic [2:0] c_fmt_b     = 3'd3;
  localparam logic [2:0] c_fmt_u     = 3'd4;
  localparam logic [2:0] c_fmt_j     = 3'd5;
  localparam logic [2:0] c_fmt_shamt = 3'd6;
  localparam logic [2:0] c_fmt_none  = 3'd7;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_reg    = 7'b0110011;
  localparam logic [6:0] c_op_system = 7'b1110011;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_fmt;
  logic            w_illegal;
  logic            w_accept;

  logic            valid_q,   valid_d;
  logic [XLEN-1:0] imm_q,     imm_d;
  logic [2:0]      fmt_q,     fmt_d;
  logic [XLEN-1:0] target_q,  target_d;
  logic            illegal_q, illegal_d;

  assign w_opcode = instruction[6:0];
  assign w_funct3 = instruction[14:12];

  // Size casts of signed operands sign-extend to XLEN for both legal widths.
  always_comb begin
    w_imm     = '0;
    w_fmt     = c_fmt_none;
    w_illegal = 1'b1;
    if (instruction[1:0] == 2'b11) begin
      w_illegal = 1'b0;
      case (w_opcode)
        c_op_load, c_op_jalr, c_op_system: begin
          w_fmt = c_fmt_i;
          w_imm = XLEN'($signed(instruction[31:20]));
        end
        c_op_imm: begin
          if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
            w_fmt = c_fmt_shamt;
            w_imm = (XLEN == 64) ? XLEN'(instruction[25:20]) : XLEN'(instruction[24:20]);
          end else begin
            w_fmt = c_fmt_i;
            w_imm = XLEN'($signed(instruction[31:20]));
          end
        end
        c_op_store: begin
          w_fmt = c_fmt_s;
          w_imm = XLEN'($signed({instruction[31:25], instruction[11:7]}));
        end
        c_op_branch: begin
          w_fmt = c_fmt_b;
          w_imm = XLEN'($signed({instruction[31], instruction[7], instruction[30:25],
                                 instruction[11:8], 1'b0}));
        end
        c_op_lui, c_op_auipc: begin
          w_fmt = c_fmt_u;
          w_imm = XLEN'($signed({instruction[31:12], 12'b0}));
        end
        c_op_jal: begin
          w_fmt = c_fmt_j;
          w_imm = XLEN'($signed({instruction[31], instruction[19:12], instruction[20],
                                 instruction[30:21], 1'b0}));
        end
        c_op_reg: begin
          w_fmt = c_fmt_r;
        end
        default: begin
          w_fmt     = c_fmt_none;
          w_illegal = 1'b1;
        end
      endcase
    end
  end

  assign in_ready = !valid_q || out_ready;
  assign w_accept = in_valid && in_ready;

  // Data registers move only on a real accept; flush merely invalidates the slot.
  always_comb begin
    valid_d   = valid_q;
    imm_d     = imm_q;
    fmt_d     = fmt_q;
    target_d  = target_q;
    illegal_d = illegal_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (w_accept) begin
      valid_d   = 1'b1;
      imm_d     = w_imm;
      fmt_d     = w_fmt;
      target_d  = pc + w_imm;
      illegal_d = w_illegal;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      imm_q     <= '0;
      fmt_q     <= c_fmt_none;
      target_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      imm_q     <= imm_d;
      fmt_q     <= fmt_d;
      target_q  <= target_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid     = valid_q;
  assign immediate_out = imm_q;
  assign fmt_out       = fmt_q;
  assign target_out    = target_q;
  assign illegal_out   = illegal_q;

endmodule
`default_nettype wire

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter XLEN, default 32, immediate/PC datapath width; legal values 32 and 64 only.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port reset  input  1  synchronous active-high reset.
REQ-005 Port flush  input  1  synchronous kill of held and incoming instruction.
REQ-006 Port in_valid  input  1  instruction/pc presented.
REQ-007 Port in_ready  output  1  stage can accept this cycle.
REQ-008 Port instruction  input  32  raw RV instruction word.
REQ-009 Port pc  input  XLEN  address of instruction.
REQ-010 Port out_valid  output  1  registered result valid.
REQ-011 Port out_ready  input  1  consumer accepts result.
REQ-012 Port immediate_out  output  XLEN  decoded immediate.
REQ-013 Port fmt_out  output  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 NONE.
REQ-014 Port target_out  output  XLEN  pc + immediate_out, modulo 2^XLEN.
REQ-015 Port illegal_out  output  1  opcode not decodable.

Function
REQ-016 Decode SHALL use instruction[6:0]: 0000011/1100111 I; 0010011 I, or SHAMT when funct3 is 001/101; 0100011 S; 1100011 B; 0110111/0010111 U; 1101111 J; 0110011 R; 1110011 I.
REQ-017 I: sign-extend instruction[31:20] to XLEN.
REQ-018 SHAMT: zero-extend instruction[24:20] for XLEN=32, instruction[25:20] for XLEN=64.
REQ-019 S: sign-extend {instruction[31:25], instruction[11:7]}.
REQ-020 B: sign-extend {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0}.
REQ-021 U: {instruction[31:12], 12'b0}, sign-extended from bit 31 to XLEN.
REQ-022 J: sign-extend {instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0}.
REQ-023 R: immediate 0, fmt 0, illegal 0.
REQ-024 Any other opcode, or instruction[1:0] != 2'b11: immediate 0, fmt 7, illegal 1.
REQ-025 target_out SHALL be computed for every format, with no masking.
REQ-026 Stage is a single registered pipeline slot; latency exactly 1 cycle from accept to out_valid.
REQ-027 in_ready = !out_valid || out_ready (combinational); accept occurs when in_valid && in_ready.
REQ-028 On accept, all outputs SHALL load on the next edge; out_valid goes or stays 1.
REQ-029 When out_valid && out_ready and no accept, out_valid SHALL clear on the next edge.
REQ-030 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-031 flush SHALL override everything: out_valid clears next edge, a same-cycle accept is discarded.
REQ-032 in_ready SHALL NOT depend on flush.
REQ-033 Data outputs are don't-care when out_valid=0 but SHALL only change on accept.

Reset
REQ-034 On reset: out_valid 0, immediate_out 0, target_out 0, fmt_out 7, illegal_out 0.
REQ-035 reset SHALL take priority over flush and accept; an in-flight result SHALL be dropped.
REQ-036 During reset, in_ready SHALL follow REQ-027 with out_valid=0.

Verification
REQ-037 XLEN=32, pc 0x100, 0xFFF00093 (addi -1) -> next cycle out_valid 1, immediate 0xFFFFFFFF, fmt 1, target 0x000000FF.
REQ-038 0xFE112E23 (sw -4) -> immediate 0xFFFFFFFC, fmt 2; 0x00000463 (beq +8) at pc 0x100 -> immediate 8, fmt 3, target 0x108.
REQ-039 XLEN=64: 0x800002B7 (lui) -> 0xFFFFFFFF80000000, fmt 4; 0x41F0D093 (srai 31) -> immediate 0x1F, fmt 6.
REQ-040 0x00000000 -> illegal 1, fmt 7, immediate 0.
REQ-041 Back-to-back stream with out_ready low 3 cycles -> outputs frozen, in_ready 0, no loss or duplication when released.
REQ-042 flush with out_valid 1 and in_valid 1 -> next cycle out_valid 0; reset asserted mid-stall -> REQ-034 values next cycle.
